regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: two writeback ports, NRD read
// ports with scoreboard busy flags, an issue-side busy set port and ready.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic                we0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                we1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                set_en;
  logic [AW-1:0]       set_addr;
  logic                ready;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, set_en, set_addr,
    input  rdata, rbusy, ready
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, set_en, set_addr,
    output rdata, rbusy, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, per-register busy
// scoreboard and a post-reset sweep that clears every register before use.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_r;
  logic [AW-1:0]       cnt_r;
  logic                ready_r;
  logic [XLEN-1:0]     regs_r [NREG];
  logic [NREG-1:0]     busy_r;
  logic [NREG-1:0]     busy_next_s;
  logic                wr0_s;
  logic                wr1_s;
  logic [AW-1:0]       ra_s   [NRD];
  logic [NRD-1:0]      hit0_s;
  logic [NRD-1:0]      hit1_s;
  logic [NRD*XLEN-1:0] rdata_s;
  logic [NRD-1:0]      rbusy_s;

  // Writes to x0 are dropped entirely, so they neither store nor touch busy.
  assign wr0_s = bus.we0 && (bus.waddr0 != {AW{1'b0}});
  assign wr1_s = bus.we1 && (bus.waddr1 != {AW{1'b0}});

  // Scoreboard next state: an issue-side set beats a same-cycle writeback clear.
  always_comb begin
    busy_next_s = busy_r;
    for (int r = 0; r < NREG; r++) begin
      busy_next_s[r] = (r != 0) &&
                       ((bus.set_en && (bus.set_addr == AW'(r))) ||
                        (busy_r[r] && !((wr0_s && (bus.waddr0 == AW'(r))) ||
                                        (wr1_s && (bus.waddr1 == AW'(r))))));
    end
  end

  // Clear sweep, then normal operation; later write to regs_r gives port 1 priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {AW{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= {NREG{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          regs_r[cnt_r] <= {XLEN{1'b0}};
          busy_r        <= {NREG{1'b0}};
          cnt_r         <= cnt_r + AW'(1);
          if (cnt_r == AW'(NREG - 1)) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wr0_s) begin
            regs_r[bus.waddr0] <= bus.wdata0;
          end
          if (wr1_s) begin
            regs_r[bus.waddr1] <= bus.wdata1;
          end
          busy_r <= busy_next_s;
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= {AW{1'b0}};
          ready_r <= 1'b0;
          busy_r  <= {NREG{1'b0}};
        end
      endcase
    end
  end

  // Combinational read ports with write bypass; a bypassed register is not busy.
  always_comb begin
    rdata_s = {(NRD*XLEN){1'b0}};
    rbusy_s = {NRD{1'b0}};
    hit0_s  = {NRD{1'b0}};
    hit1_s  = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      ra_s[i]   = bus.raddr[i*AW +: AW];
      hit1_s[i] = bus.we1 && (bus.waddr1 == ra_s[i]);
      hit0_s[i] = bus.we0 && (bus.waddr0 == ra_s[i]);
      if (!rst && ready_r && bus.re[i] && (ra_s[i] != {AW{1'b0}})) begin
        if (hit1_s[i]) begin
          rdata_s[i*XLEN +: XLEN] = bus.wdata1;
        end else if (hit0_s[i]) begin
          rdata_s[i*XLEN +: XLEN] = bus.wdata0;
        end else begin
          rdata_s[i*XLEN +: XLEN] = regs_r[ra_s[i]];
        end
        rbusy_s[i] = busy_r[ra_s[i]] && !hit0_s[i] && !hit1_s[i];
      end else begin
        rdata_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rbusy_s[i]              = 1'b0;
      end
    end
  end

  assign bus.rdata = rdata_s;
  assign bus.rbusy = rbusy_s;
  assign bus.ready = ready_r;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a behavioural model checked every cycle plus
// hand-computed literal expectations around the interesting scenarios.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors  = 0;
  int checks  = 0;
  bit started = 1'b0;

  // Model: clear_left counts remaining sweep cycles; registers are all zero once it reaches 0.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  int              clear_left = NREG;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] ra(input int i);
    return bus.raddr[i*AW +: AW];
  endfunction

  function automatic logic [XLEN-1:0] rd(input int i);
    return bus.rdata[i*XLEN +: XLEN];
  endfunction

  function automatic bit wrote(input int r);
    return (bus.we0 && bus.waddr0 == AW'(r)) || (bus.we1 && bus.waddr1 == AW'(r));
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int i);
    if (rst || clear_left != 0 || !bus.re[i] || ra(i) == 5'd0) return 32'd0;
    if (bus.we1 && bus.waddr1 == ra(i)) return bus.wdata1;
    if (bus.we0 && bus.waddr0 == ra(i)) return bus.wdata0;
    return m_regs[ra(i)];
  endfunction

  function automatic logic exp_busy(input int i);
    if (rst || clear_left != 0 || !bus.re[i] || ra(i) == 5'd0) return 1'b0;
    return m_busy[ra(i)] && !wrote(int'(ra(i)));
  endfunction

  // Model state update on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      clear_left <= NREG;
      for (int r = 0; r < NREG; r++) m_busy[r] <= 1'b0;
    end else if (clear_left != 0) begin
      clear_left <= clear_left - 1;
      if (clear_left == 1) for (int r = 0; r < NREG; r++) m_regs[r] <= 32'd0;
    end else begin
      if (bus.we0 && bus.waddr0 != 5'd0 && !(bus.we1 && bus.waddr1 == bus.waddr0))
        m_regs[bus.waddr0] <= bus.wdata0;
      if (bus.we1 && bus.waddr1 != 5'd0)
        m_regs[bus.waddr1] <= bus.wdata1;
      for (int r = 1; r < NREG; r++) begin
        if (bus.set_en && bus.set_addr == AW'(r)) m_busy[r] <= 1'b1;
        else if (wrote(r)) m_busy[r] <= 1'b0;
      end
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("ready", {31'd0, bus.ready}, {31'd0, (!rst && clear_left == 0) || (rst && bus.ready)});
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("rdata%0d", i), rd(i), exp_rd(i));
        chk($sformatf("rbusy%0d", i), {31'd0, bus.rbusy[i]}, {31'd0, exp_busy(i)});
      end
    end
  end

  task automatic idle();
    bus.we0 = 1'b0; bus.waddr0 = 5'd0; bus.wdata0 = 32'd0;
    bus.we1 = 1'b0; bus.waddr1 = 5'd0; bus.wdata1 = 32'd0;
    bus.re = 2'b00; bus.raddr = 10'd0;
    bus.set_en = 1'b0; bus.set_addr = 5'd0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    bus.re = 2'b11;
    bus.raddr = {a1, a0};
  endtask

  // Release reset, optionally driving ignored traffic early in the sweep, and count cycles to ready.
  task automatic release_and_wait(input string name, input bit garbage);
    int n;
    n = 0;
    rst = 1'b0;
    if (garbage) begin
      bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'hDEADBEEF;
      bus.we1 = 1'b1; bus.waddr1 = 5'd4; bus.wdata1 = 32'hCAFEF00D;
      bus.set_en = 1'b1; bus.set_addr = 5'd3;
      rd2(5'd3, 5'd4);
    end
    while (n < 100) begin
      next();
      n++;
      if (n == 10) idle();
      @(negedge clk);
      if (bus.ready) break;
    end
    chk(name, n, NREG);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    started = 1'b1;
    next();
    @(negedge clk);
    chk("reset_ready", {31'd0, bus.ready}, 32'd0);
    next();
    release_and_wait("clear_cycles_first", 1'b1);

    // Traffic during the sweep must have been ignored.
    next(); rd2(5'd3, 5'd4);
    @(negedge clk);
    chk("clear_ignored_x3", rd(0), 32'd0);
    chk("clear_ignored_x4", rd(1), 32'd0);
    chk("clear_ignored_busy", {30'd0, bus.rbusy}, 32'd0);

    // Bypass on write, then array value next cycle.
    next(); idle();
    bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hAAAA0001;
    bus.re = 2'b01; bus.raddr = {5'd0, 5'd5};
    @(negedge clk);
    chk("bypass_x5", rd(0), 32'hAAAA0001);
    next(); bus.we0 = 1'b0;
    @(negedge clk);
    chk("stored_x5", rd(0), 32'hAAAA0001);

    // Both write ports to x7: port 1 wins.
    next(); idle();
    bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h11;
    bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h22;
    rd2(5'd7, 5'd7);
    @(negedge clk);
    chk("conflict_p0", rd(0), 32'h22);
    chk("conflict_p1", rd(1), 32'h22);
    next(); bus.we0 = 1'b0; bus.we1 = 1'b0;
    @(negedge clk);
    chk("conflict_stored", rd(0), 32'h22);

    // x0 is immutable and never busy.
    next(); idle();
    bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFFFFFF;
    bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'hFFFFFFFF;
    bus.set_en = 1'b1; bus.set_addr = 5'd0;
    rd2(5'd0, 5'd0);
    @(negedge clk);
    chk("x0_rdata", rd(0), 32'd0);
    next(); idle(); rd2(5'd0, 5'd0);
    @(negedge clk);
    chk("x0_after", rd(1), 32'd0);
    chk("x0_busy", {30'd0, bus.rbusy}, 32'd0);

    // Scoreboard set / bypass clear / set-beats-clear on x9.
    next(); idle();
    bus.set_en = 1'b1; bus.set_addr = 5'd9;
    rd2(5'd0, 5'd9);
    @(negedge clk);
    chk("busy_not_yet", {31'd0, bus.rbusy[1]}, 32'd0);
    next(); bus.set_en = 1'b0;
    @(negedge clk);
    chk("busy_set", {31'd0, bus.rbusy[1]}, 32'd1);
    next(); bus.re = 2'b00;
    @(negedge clk);
    chk("busy_re_off", {31'd0, bus.rbusy[1]}, 32'd0);
    next(); rd2(5'd0, 5'd9);
    bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h55;
    @(negedge clk);
    chk("busy_bypass", {31'd0, bus.rbusy[1]}, 32'd0);
    chk("bypass_x9", rd(1), 32'h55);
    next(); bus.we1 = 1'b0;
    @(negedge clk);
    chk("busy_cleared", {31'd0, bus.rbusy[1]}, 32'd0);
    next();
    bus.set_en = 1'b1; bus.set_addr = 5'd9;
    bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h66;
    @(negedge clk);
    chk("setclr_same", {31'd0, bus.rbusy[1]}, 32'd0);
    next(); idle(); rd2(5'd9, 5'd9);
    @(negedge clk);
    chk("set_wins", {31'd0, bus.rbusy[0]}, 32'd1);
    chk("set_wins_data", rd(0), 32'h66);

    // Table of dual-port writes with reads of neighbouring registers.
    for (int k = 1; k <= 8; k++) begin
      next(); idle();
      bus.we0 = 1'b1; bus.waddr0 = AW'(k);      bus.wdata0 = 32'h01000001 * k;
      bus.we1 = 1'b1; bus.waddr1 = AW'(k + 16); bus.wdata1 = 32'h0F0F0000 | k;
      rd2(AW'(k), AW'(k + 15));
    end
    next(); idle(); rd2(5'd4, 5'd20);
    @(negedge clk);
    chk("table_x4", rd(0), 32'h04000004);
    chk("table_x20", rd(1), 32'h0F0F0004);

    // Reset mid-RUN, then again mid-CLEAR; each restarts the full sweep.
    next(); rst = 1'b1;
    next(); rst = 1'b0;
    repeat (10) next();
    rst = 1'b1;
    next();
    release_and_wait("clear_cycles_restart", 1'b0);
    for (int r = 0; r < NREG; r++) begin
      next(); rd2(AW'(r), AW'(r));
      @(negedge clk);
      chk($sformatf("after_reset_x%0d", r), rd(0), 32'd0);
      chk($sformatf("after_reset_busy_x%0d", r), {30'd0, bus.rbusy}, 32'd0);
    end

    next(); idle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
